// File: rtl/alu_share_ctrl.sv
// Round-robin share of one 16-bit ALU between two requesters, with a registered
// response channel and the Z/V/N flag register. Optional sticky error: ALU_ERR_STICKY_EN.
module alu_share_ctrl #(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  output logic [OPW-1:0] alu_opcode,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_err,
  input  logic [2:0]     alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  output logic [2:0]     flags_q
`ifdef ALU_ERR_STICKY_EN
  ,
  input  logic           err_clr,
  output logic           err_sticky
`endif
);

  localparam int unsigned FW = 3;

  localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR    = OPW'(2);
  localparam logic [OPW-1:0] OP_SLL    = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA    = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR    = OPW'(6);

  localparam logic [FW-1:0] MASK_ALL  = 3'b111;
  localparam logic [FW-1:0] MASK_Z    = 3'b100;
  localparam logic [FW-1:0] MASK_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic            grant_id_c;
  logic            accept_c;
  logic [OPW-1:0]  sel_op_c;
  logic [DW-1:0]   sel_a_c;
  logic [DW-1:0]   sel_b_c;
  logic [FW-1:0]   flag_mask_c;
  logic            exec_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, round-robin grant and combinational ready
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id_c = 1'b0;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || last_grant)) begin
            req0_ready = 1'b1;
            grant_id_c = 1'b0;
            accept_c   = 1'b1;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            grant_id_c = 1'b1;
            accept_c   = 1'b1;
          end
        end
        if (accept_c) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign exec_c = (state == EXEC);

  // Operand source of the granted requester
  always_comb begin
    sel_op_c = req0_op;
    sel_a_c  = req0_a;
    sel_b_c  = req0_b;
    if (grant_id_c) begin
      sel_op_c = req1_op;
      sel_a_c  = req1_a;
      sel_b_c  = req1_b;
    end
  end

  // Latched operands double as the ALU drive, so they stay stable outside EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept_c) begin
      alu_in1    <= sel_a_c;
      alu_in2    <= sel_b_c;
      alu_opcode <= sel_op_c;
      rsp_id     <= grant_id_c;
      last_grant <= grant_id_c;
    end
  end

  // Result capture and response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (exec_c) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_out;
        rsp_err   <= alu_err;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Which of {Z,V,N} the current opcode is allowed to write
  always_comb begin
    flag_mask_c = MASK_NONE;
    case (alu_opcode)
      OP_ADD, OP_SUB:                 flag_mask_c = MASK_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask_c = MASK_Z;
      default:                        flag_mask_c = MASK_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (exec_c) begin
      flags_q <= (flags_q & ~flag_mask_c) | (alu_flags & flag_mask_c);
    end
  end

`ifdef ALU_ERR_STICKY_EN
  // A capture with an error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (exec_c && alu_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule
